// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the M stage of the pipelined MIPS datapath.
//   Stores are queued in a small circular write buffer and retired to RAM one
//   per cycle whenever the RAM port is not needed for a load. Loads see the
//   youngest buffered store to the same word before falling back to RAM. One
//   word-addressed I/O register (io_out) sits at IO_ADDR and bypasses the
//   buffer entirely.
//
// Ports
//   clock       system clock, all state on posedge
//   reset       synchronous, active-high
//   dmem_we     store request
//   dmem_re     load request
//   dmem_addr   byte address; [1:0] ignored, bits above the RAM index alias
//   dmem_wd     store data
//   dmem_rd     load data, combinational in the request cycle (0 when !dmem_re)
//   dmem_stall  store refused this cycle, M stage must hold and re-present it
//   io_out      I/O register contents
//   wb_count    entries currently buffered
//   wb_empty    wb_count == 0
//
// Handshake: a store is accepted on a rising edge where dmem_we=1 and
// dmem_stall=0. dmem_stall depends only on dmem_we, the address and the
// registered count, so it is stable for the whole cycle; a refused store is
// simply dropped and the datapath presents it again on a later cycle.
// Loads never stall.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WB_DEPTH    = 4,
  parameter logic [31:0] IO_ADDR     = 32'h0000_FF00
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dmem_we,
  input  logic                        dmem_re,
  input  logic [31:0]                 dmem_addr,
  input  logic [31:0]                 dmem_wd,
  output logic [31:0]                 dmem_rd,
  output logic                        dmem_stall,
  output logic [31:0]                 io_out,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_empty
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [29:0]   IO_WORD = IO_ADDR[31:2];
  localparam logic [CW-1:0] WB_FULL = CW'(WB_DEPTH);

  // Storage
  logic [31:0]   ram     [DEPTH_WORDS];
  logic [AW-1:0] wb_idx  [WB_DEPTH];
  logic [31:0]   wb_data [WB_DEPTH];

  // Buffer pointers; widths are a power-of-two so they wrap on overflow
  logic [PW-1:0] wb_head;
  logic [PW-1:0] wb_tail;

  // Decode
  logic [AW-1:0] idx;
  logic          io_hit;
  logic          push;
  logic          io_write;
  logic          drain;
  logic          unused_addr_bits;

  assign idx              = dmem_addr[AW+1:2];
  assign io_hit           = (dmem_addr[31:2] == IO_WORD);
  assign unused_addr_bits = ^dmem_addr[1:0];

  assign wb_empty   = (wb_count == '0);
  // A drain in the same cycle does not free a slot early: the count is the
  // registered value, which keeps stall off the drain path.
  assign dmem_stall = dmem_we & ~io_hit & (wb_count == WB_FULL);
  assign push       = dmem_we & ~io_hit & ~dmem_stall;
  assign io_write   = dmem_we & io_hit;
  // Loads own the single RAM port; reset also suppresses the retiring write
  assign drain      = ~wb_empty & ~dmem_re & ~reset;

  // Pointer / count / IO register state
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_head  <= '0;
      wb_tail  <= '0;
      wb_count <= '0;
      io_out   <= '0;
    end else begin
      if (push)  wb_tail <= wb_tail + 1'b1;
      if (drain) wb_head <= wb_head + 1'b1;
      case ({push, drain})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: wb_count <= wb_count;
      endcase
      if (io_write) io_out <= dmem_wd;
    end
  end

  // Buffer entry storage (no reset needed: validity comes from the pointers)
  always_ff @(posedge clock) begin
    if (push) begin
      wb_idx[wb_tail]  <= idx;
      wb_data[wb_tail] <= dmem_wd;
    end
  end

  // RAM write port, fed only by the buffer head
  always_ff @(posedge clock) begin
    if (drain) begin
      ram[wb_idx[wb_head]] <= wb_data[wb_head];
    end
  end

  // Youngest-match search: walk oldest to youngest over the valid entries,
  // so a later match overwrites an earlier one.
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] pos;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pos      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      pos = wb_head + PW'(i);
      if ((CW'(i) < wb_count) && (wb_idx[pos] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[pos];
      end
    end
  end

  // Load data, asynchronous read; a same-cycle store is not yet visible
  always_comb begin
    dmem_rd = '0;
    if (dmem_re) begin
      if (io_hit)       dmem_rd = io_out;
      else if (fwd_hit) dmem_rd = fwd_data;
      else              dmem_rd = ram[idx];
    end
  end

endmodule
